// File: rtl/mem_bus_arbiter.sv
// Round-robin two-requester arbiter and transfer sequencer for the shared 8-bit
// memory bus; writes below ROM_LIMIT are rejected and flagged with err.
module mem_bus_arbiter #(
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [7:0]  ROM_LIMIT  = 8'h80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t     state_r, state_nxt_s;
    logic [2:0] cnt_r, cnt_nxt_s;
    logic       last_grant_r, owner_r, wr_r, err_pend_r, mem_we_r;
    logic [7:0] mem_addr_r, mem_wdata_r, rdata0_r, rdata1_r;
    logic       ack0_r, ack1_r, err0_r, err1_r;
    logic       winner_s, grant_s, cap_rdata_s, ack_set_s;
    logic       sel_wr_s, rom_hit_s;
    logic [7:0] sel_addr_s, sel_wdata_s;

    // Winner selection: a tie goes to the requester that did not win last time.
    always_comb begin
        winner_s = 1'b0;
        if (req0 && req1) begin
            winner_s = ~last_grant_r;
        end else if (req1) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        sel_wr_s    = winner_s ? wr1    : wr0;
        sel_addr_s  = winner_s ? addr1  : addr0;
        sel_wdata_s = winner_s ? wdata1 : wdata0;
        rom_hit_s   = (sel_addr_s < ROM_LIMIT);
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        grant_s     = 1'b0;
        cap_rdata_s = 1'b0;
        ack_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (wr_r) begin
                    ack_set_s   = 1'b1;
                    state_nxt_s = ACK;
                end else begin
                    cnt_nxt_s   = 3'(RD_LATENCY);
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == 3'd1) begin
                    cnt_nxt_s   = 3'd0;
                    cap_rdata_s = 1'b1;
                    ack_set_s   = 1'b1;
                    state_nxt_s = ACK;
                end else begin
                    cnt_nxt_s   = cnt_r - 3'd1;
                    state_nxt_s = WAIT;
                end
            end
            ACK: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Bus registers, grant bookkeeping and per-requester completion outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            wr_r         <= 1'b0;
            err_pend_r   <= 1'b0;
            mem_addr_r   <= 8'h00;
            mem_wdata_r  <= 8'h00;
            mem_we_r     <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            err0_r       <= 1'b0;
            err1_r       <= 1'b0;
            rdata0_r     <= 8'h00;
            rdata1_r     <= 8'h00;
        end else begin
            mem_we_r <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            err0_r   <= 1'b0;
            err1_r   <= 1'b0;
            if (grant_s) begin
                owner_r      <= winner_s;
                last_grant_r <= winner_s;
                wr_r         <= sel_wr_s;
                mem_addr_r   <= sel_addr_s;
                mem_wdata_r  <= sel_wdata_s;
                mem_we_r     <= sel_wr_s & ~rom_hit_s;
                err_pend_r   <= sel_wr_s & rom_hit_s;
            end
            // err_pend_r is only ever set by a write, so reads complete with err = 0.
            if (ack_set_s) begin
                if (owner_r) begin
                    ack1_r <= 1'b1;
                    err1_r <= err_pend_r;
                end else begin
                    ack0_r <= 1'b1;
                    err0_r <= err_pend_r;
                end
            end
            if (cap_rdata_s) begin
                if (owner_r) begin
                    rdata1_r <= mem_rdata;
                end else begin
                    rdata0_r <= mem_rdata;
                end
            end
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign err0      = err0_r;
    assign err1      = err1_r;
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;
    assign owner     = owner_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer sitting in front of the 8-bit memory system: boot ROM at 0x00–0x7F, data RAM at 0x80–0xDF, I/O ports above. It grants the single shared memory bus (address, write data, write enable, read data) to one of two requesters at a time, such as a CPU core and a DMA/loader engine. Arbitration is round-robin. The block sequences each transfer through issue, read-latency wait and acknowledge phases, and it blocks writes into the ROM region.

## Interface
Parameters:
- RD_LATENCY, 1, cycles from the edge that samples mem_addr to mem_rdata being valid; legal range 1–4.
- ROM_LIMIT, 8'h80, first writable address; writes to addresses below it are rejected.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  transfer request from requester 0 / 1; held high until the matching ack.
- wr0 / wr1  input  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  input  8  transfer address; stable while req is high.
- wdata0 / wdata1  input  8  write data; stable while req is high.
- ack0 / ack1  output  1  one-cycle completion pulse.
- err0 / err1  output  1  valid with ack; 1 = write rejected (ROM region).
- rdata0 / rdata1  output  8  read data; valid with ack, held until that requester's next read completes.
- mem_addr  output  8  registered bus address.
- mem_wdata  output  8  registered bus write data.
- mem_we  output  1  registered bus write enable.
- mem_rdata  input  8  read data returned by the memory system.
- busy  output  1  high in every state except IDLE.
- owner  output  1  requester currently granted; meaningful only while busy.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req is high, select the winner, latch its wr/addr/wdata into the bus registers, set owner, and go to ISSUE.
  - If no req is high, stay in IDLE.
- Round-robin rules:
  - A last_grant register records the most recent winner.
  - When both requests are high, the requester that is not last_grant wins.
  - A lone request wins regardless of last_grant.
  - last_grant updates on entry to ISSUE.
- ISSUE (1 cycle): mem_addr and mem_wdata are driven with the latched values.
  - Write with addr >= ROM_LIMIT: mem_we = 1 for this cycle only; next state ACK.
  - Write with addr < ROM_LIMIT: mem_we stays 0, the error flag is set, next state ACK.
  - Read: mem_we = 0; next state WAIT with the latency counter loaded to RD_LATENCY.
- WAIT: the counter decrements each cycle. On the edge where it reaches 0, sample mem_rdata into the owner's rdata register and go to ACK.
- ACK (1 cycle): ack of the owner = 1. err of the owner = 1 only for a rejected write. Next state is always IDLE.
- The non-owner's ack, err and rdata are never disturbed.
- A requester that keeps req high through ACK starts a new transaction. It competes in IDLE under round-robin, so two continuously requesting masters alternate strictly.
- mem_addr and mem_wdata hold their last values outside ISSUE and WAIT. mem_we is 0 in every state except ISSUE-write.
- Changes to req, addr, wr or wdata after the IDLE latch edge are ignored until the next IDLE.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, last_grant = 1 (so requester 0 wins the first tie).
  - owner = 0, busy = 0.
  - mem_addr = 0, mem_wdata = 0, mem_we = 0.
  - ack0/1 = 0, err0/1 = 0, rdata0/1 = 0.
- Reset mid-transfer aborts with no ack. mem_we drops at once, so a partial write cycle is allowed but never repeated.
- Let edge E be the IDLE edge that samples req.
- Write latency: ISSUE is the cycle after E; ack is high in the 2nd cycle after E.
- Read latency: ack is high in the (2 + RD_LATENCY)th cycle after E (3rd at default). rdata is valid in the same cycle as ack.
- Bus occupancy: 3 cycles per write and 3 + RD_LATENCY cycles per read, including the IDLE cycle. Minimum req-to-req spacing equals the occupancy.
- Address wrap: no arithmetic on addresses; 0xFF is a legal, writable address (port region).

## Test plan
- Reset, then single read: req0 = 1, wr0 = 0, addr0 = 0x10, memory returns 0x5A.
  - mem_addr = 0x10 in ISSUE.
  - ack0 pulses 3 cycles after the sampling edge, with rdata0 = 0x5A and err0 = 0.
  - ack1 stays 0.
- Write to RAM: req1 writes 0xC3 to 0x85.
  - mem_we = 1 for exactly one cycle with mem_addr = 0x85 and mem_wdata = 0xC3.
  - ack1 pulses 2 cycles after the sampling edge with err1 = 0.
- ROM write protection: req0 writes 0x77 to 0x40.
  - mem_we never rises.
  - ack0 and err0 both pulse in the same cycle.
  - A following write to 0x80 succeeds with err0 = 0.
- Contention: req0 and req1 rise together and stay high for 4 transactions, all reads.
  - Grants go 0, 1, 0, 1.
  - Acks never overlap.
  - rdata0 and rdata1 each hold their own returned data.
- Latency parameter: RD_LATENCY = 3 read.
  - ack appears 5 cycles after the sampling edge.
  - rdata equals the mem_rdata value on the 3rd WAIT edge, not the earlier bus values.
- Reset mid-read: assert reset during WAIT.
  - All outputs return to their reset values immediately.
  - No ack is issued.
  - After release, a pending req1 is served normally.
